// File: rtl/flash_arb_pkg.sv
// Shared types and client identifiers for the flash read arbiter.
package flash_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DATA = 2'd2
   } arb_state_t;

   typedef logic client_id_t;

   localparam client_id_t CLIENT_AUDIO = 1'b0;
   localparam client_id_t CLIENT_AUX   = 1'b1;

endpackage

// File: rtl/watchdog_counter.sv
// Saturating cycle counter that flags when a flash read has waited too long.
module watchdog_counter #(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wd_cnt;

   // count while enabled, stick at the maximum instead of wrapping
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wd_cnt <= '0;
      end else if (enable && (wd_cnt != CNT_MAX)) begin
         wd_cnt <= wd_cnt + CNT_W'(1);
      end
   end

   assign tc = (wd_cnt == CNT_TC);

endmodule

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM flash read port between two
// read masters, one read outstanding at a time, with a stuck-read watchdog.
module flash_read_arbiter
   import flash_arb_pkg::*;
#(
   parameter int ADDR_W         = 23,
   parameter int DATA_W         = 32,
   parameter int BE_W           = 4,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c0_read,
   input  logic [ADDR_W-1:0] c0_address,
   input  logic [BE_W-1:0]   c0_byteenable,
   output logic              c0_waitrequest,
   output logic [DATA_W-1:0] c0_readdata,
   output logic              c0_readdatavalid,
   input  logic              c1_read,
   input  logic [ADDR_W-1:0] c1_address,
   input  logic [BE_W-1:0]   c1_byteenable,
   output logic              c1_waitrequest,
   output logic [DATA_W-1:0] c1_readdata,
   output logic              c1_readdatavalid,
   output logic              flsh_read,
   output logic [ADDR_W-1:0] flsh_address,
   output logic [BE_W-1:0]   flsh_byteenable,
   input  logic              flsh_waitrequest,
   input  logic [DATA_W-1:0] flsh_readdata,
   input  logic              flsh_readdatavalid,
   output logic              timeout_err
);

   arb_state_t        state_q, state_d;
   client_id_t        grant_q, grant_d;
   client_id_t        rr_ptr;
   logic [ADDR_W-1:0] addr_q;
   logic [BE_W-1:0]   be_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        rvalid_q;
   logic              timeout_q;
   logic              flsh_read_q;
   logic              latch, accept, data_done, forced_done;
   logic              wd_tc;

   watchdog_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk   (clk),
      .rst   (rst),
      .clear (accept),
      .enable(state_q == WAIT_DATA),
      .tc    (wd_tc)
   );

   // next-state, grant choice and client stall; flash stall passes straight
   // through to the granted client so both see the accept in the same cycle
   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      latch          = 1'b0;
      accept         = 1'b0;
      data_done      = 1'b0;
      forced_done    = 1'b0;
      c0_waitrequest = 1'b1;
      c1_waitrequest = 1'b1;
      case (state_q)
         IDLE: begin
            if (c0_read || c1_read) begin
               latch   = 1'b1;
               state_d = ISSUE;
               if (c0_read && c1_read) grant_d = rr_ptr;
               else                    grant_d = c1_read ? CLIENT_AUX : CLIENT_AUDIO;
            end
         end
         ISSUE: begin
            if (grant_q == CLIENT_AUX) c1_waitrequest = flsh_waitrequest;
            else                       c0_waitrequest = flsh_waitrequest;
            if (!flsh_waitrequest) begin
               accept  = 1'b1;
               state_d = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            // real data beats the watchdog when both land together
            if (flsh_readdatavalid) begin
               data_done = 1'b1;
               state_d   = IDLE;
            end else if (wd_tc) begin
               forced_done = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state, request latch, flash command and completion registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= CLIENT_AUDIO;
         rr_ptr      <= CLIENT_AUDIO;
         addr_q      <= '0;
         be_q        <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 2'b00;
         timeout_q   <= 1'b0;
         flsh_read_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rvalid_q  <= 2'b00;
         timeout_q <= 1'b0;
         if (latch) begin
            flsh_read_q <= 1'b1;
            addr_q      <= (grant_d == CLIENT_AUX) ? c1_address    : c0_address;
            be_q        <= (grant_d == CLIENT_AUX) ? c1_byteenable : c0_byteenable;
         end
         if (accept) flsh_read_q <= 1'b0;
         if (data_done || forced_done) begin
            rdata_q   <= data_done ? flsh_readdata : '0;
            rvalid_q  <= (grant_q == CLIENT_AUX) ? 2'b10 : 2'b01;
            timeout_q <= forced_done;
            rr_ptr    <= ~grant_q;
         end
      end
   end

   assign flsh_read        = flsh_read_q;
   assign flsh_address     = addr_q;
   assign flsh_byteenable  = be_q;
   assign c0_readdata      = rdata_q;
   assign c1_readdata      = rdata_q;
   assign c0_readdatavalid = rvalid_q[0];
   assign c1_readdatavalid = rvalid_q[1];
   assign timeout_err      = timeout_q;

endmodule
